// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Two wrapping counters (hc, vc) step on each pixel tick (pix_en). A registered
// output stage turns the current position into sync, display-enable,
// coordinates and one-clock event strobes, all mutually aligned.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN builds a 16-bit frame counter;
// without it frame_count is tied to zero and no counter register exists.
module vga_timing_gen #(
    parameter int   H_VA  = 640,
    parameter int   H_FP  = 16,
    parameter int   H_SP  = 96,
    parameter int   H_BP  = 48,
    parameter int   V_VA  = 480,
    parameter int   V_FP  = 10,
    parameter int   V_SP  = 2,
    parameter int   V_BP  = 33,
    parameter logic H_POL = 1'b0,
    parameter logic V_POL = 1'b0,
    parameter int   H_CW  = 10,
    parameter int   V_CW  = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pix_en,
    output logic            h_sync,
    output logic            v_sync,
    output logic            display_on,
    output logic [H_CW-1:0] pixel_x,
    output logic [V_CW-1:0] pixel_y,
    output logic            line_start,
    output logic            frame_start,
    output logic            vblank_start,
    output logic [15:0]     frame_count
);

    localparam int H_TOTAL = H_VA + H_FP + H_SP + H_BP;
    localparam int V_TOTAL = V_VA + V_FP + V_SP + V_BP;

    localparam logic [H_CW-1:0] H_LAST      = H_CW'(H_TOTAL - 1);
    localparam logic [H_CW-1:0] H_VIS       = H_CW'(H_VA);
    localparam logic [H_CW-1:0] H_SYNC_BEG  = H_CW'(H_VA + H_FP);
    localparam logic [H_CW-1:0] H_SYNC_END  = H_CW'(H_VA + H_FP + H_SP - 1);
    localparam logic [V_CW-1:0] V_LAST      = V_CW'(V_TOTAL - 1);
    localparam logic [V_CW-1:0] V_VIS       = V_CW'(V_VA);
    localparam logic [V_CW-1:0] V_SYNC_BEG  = V_CW'(V_VA + V_FP);
    localparam logic [V_CW-1:0] V_SYNC_END  = V_CW'(V_VA + V_FP + V_SP - 1);

    logic [H_CW-1:0] hc_q, hc_d;
    logic [V_CW-1:0] vc_q, vc_d;
    logic            h_wrap, v_wrap;

    logic            h_sync_q, h_sync_d;
    logic            v_sync_q, v_sync_d;
    logic            display_on_q, display_on_d;
    logic [H_CW-1:0] pixel_x_q;
    logic [V_CW-1:0] pixel_y_q;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;
    logic            vblank_start_q, vblank_start_d;

    // Raster counter next state: advance one pixel per tick, wrapping line then frame.
    always_comb begin
        hc_d   = hc_q;
        vc_d   = vc_q;
        h_wrap = (hc_q == H_LAST);
        v_wrap = (vc_q == V_LAST);
        if (pix_en) begin
            if (h_wrap) begin
                hc_d = '0;
                vc_d = v_wrap ? '0 : vc_q + V_CW'(1);
            end else begin
                hc_d = hc_q + H_CW'(1);
            end
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    // Decode the current position into the values the output stage will capture.
    always_comb begin
        h_sync_d       = ((hc_q >= H_SYNC_BEG) && (hc_q <= H_SYNC_END)) ? H_POL : ~H_POL;
        v_sync_d       = ((vc_q >= V_SYNC_BEG) && (vc_q <= V_SYNC_END)) ? V_POL : ~V_POL;
        display_on_d   = (hc_q < H_VIS) && (vc_q < V_VIS);
        line_start_d   = (hc_q == '0);
        frame_start_d  = (hc_q == '0) && (vc_q == '0);
        vblank_start_d = (hc_q == '0) && (vc_q == V_VIS);
    end

    // Output stage: levels hold between ticks, strobes last exactly one clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync_q       <= ~H_POL;
            v_sync_q       <= ~V_POL;
            display_on_q   <= 1'b0;
            pixel_x_q      <= '0;
            pixel_y_q      <= '0;
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            line_start_q   <= 1'b0;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
            if (pix_en) begin
                h_sync_q       <= h_sync_d;
                v_sync_q       <= v_sync_d;
                display_on_q   <= display_on_d;
                pixel_x_q      <= hc_q;
                pixel_y_q      <= vc_q;
                line_start_q   <= line_start_d;
                frame_start_q  <= frame_start_d;
                vblank_start_q <= vblank_start_d;
            end
        end
    end

    assign h_sync       = h_sync_q;
    assign v_sync       = v_sync_q;
    assign display_on   = display_on_q;
    assign pixel_x      = pixel_x_q;
    assign pixel_y      = pixel_y_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;
    assign vblank_start = vblank_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] frame_count_q;

    // Frame tally bumps when the raster wraps to (0,0).
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (pix_en && h_wrap && v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    // The published count trails the tally by one tick so it changes with frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q   <= 16'd0;
            frame_count_q <= 16'd0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            if (pix_en) begin
                frame_count_q <= frame_cnt_q;
            end
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen using a small mode
// (14 x 7 raster, active-high syncs) so many frames fit in a short run.
// The reference model derives each output from the count of pixel ticks since
// reset using plain division and modulo.
module tb_vga_timing_gen;

    localparam int   HVA = 8, HFP = 2, HSP = 3, HBP = 1;
    localparam int   VVA = 4, VFP = 1, VSP = 1, VBP = 1;
    localparam logic HPOL = 1'b1, VPOL = 1'b1;
    localparam int   HCW = 4, VCW = 3;
    localparam int   HT = HVA + HFP + HSP + HBP;
    localparam int   VT = VVA + VFP + VSP + VBP;

    typedef struct {
        logic hs;
        logic vs;
        logic de;
        int   x;
        int   y;
        logic ls;
        logic fs;
        logic vb;
        int   fc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           pix_en;
    logic           h_sync, v_sync, display_on;
    logic [HCW-1:0] pixel_x;
    logic [VCW-1:0] pixel_y;
    logic           line_start, frame_start, vblank_start;
    logic [15:0]    frame_count;

    exp_t scoreboard[$];
    exp_t cur;
    int   pixIdx   = 0;
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    vga_timing_gen #(
        .H_VA(HVA), .H_FP(HFP), .H_SP(HSP), .H_BP(HBP),
        .V_VA(VVA), .V_FP(VFP), .V_SP(VSP), .V_BP(VBP),
        .H_POL(HPOL), .V_POL(VPOL), .H_CW(HCW), .V_CW(VCW)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en),
        .h_sync(h_sync), .v_sync(v_sync), .display_on(display_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Outputs expected for the p-th pixel tick after reset.
    function automatic exp_t pixelModel(input int p);
        exp_t e;
        int x, y;
        x = p % HT;
        y = (p / HT) % VT;
        e.x  = x;
        e.y  = y;
        e.de = (x < HVA) && (y < VVA);
        e.hs = (x >= HVA + HFP && x < HVA + HFP + HSP) ? HPOL : ~HPOL;
        e.vs = (y >= VVA + VFP && y < VVA + VFP + VSP) ? VPOL : ~VPOL;
        e.ls = (x == 0);
        e.fs = (x == 0) && (y == 0);
        e.vb = (x == 0) && (y == VVA);
`ifdef VGA_TIMING_FRAME_CNT_EN
        e.fc = (p / (HT * VT)) % 65536;
`else
        e.fc = 0;
`endif
        return e;
    endfunction

    function automatic exp_t resetModel();
        exp_t e;
        e.hs = ~HPOL; e.vs = ~VPOL; e.de = 1'b0;
        e.x = 0; e.y = 0;
        e.ls = 1'b0; e.fs = 1'b0; e.vb = 1'b0;
        e.fc = 0;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs they should produce.
    task automatic applyStimulus(input logic r, input logic en);
        @(negedge clk);
        rst    = r;
        pix_en = en;
        if (r) begin
            cur    = resetModel();
            pixIdx = 0;
        end else if (en) begin
            cur    = pixelModel(pixIdx);
            pixIdx = pixIdx + 1;
        end else begin
            cur.ls = 1'b0;
            cur.fs = 1'b0;
            cur.vb = 1'b0;
        end
        scoreboard.push_back(cur);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s cycle=%0d actual=%0h required=%0h", name, cycle, act, exp);
        end
    endtask

    // Monitor: every clock presents a new output set; compare it with the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle = cycle + 1;
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                checkOutput("h_sync",       32'(h_sync),       32'(e.hs));
                checkOutput("v_sync",       32'(v_sync),       32'(e.vs));
                checkOutput("display_on",   32'(display_on),   32'(e.de));
                checkOutput("pixel_x",      32'(pixel_x),      32'(e.x));
                checkOutput("pixel_y",      32'(pixel_y),      32'(e.y));
                checkOutput("line_start",   32'(line_start),   32'(e.ls));
                checkOutput("frame_start",  32'(frame_start),  32'(e.fs));
                checkOutput("vblank_start", 32'(vblank_start), 32'(e.vb));
                checkOutput("frame_count",  32'(frame_count),  32'(e.fc));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        pix_en = 1'b1;
        cur    = resetModel();
        $display("[TB] start: raster %0d x %0d", HT, VT);

        // Reset held for three clocks with the pixel tick running.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);

        // Free-running one pixel per clock across several frames.
        for (int i = 0; i < 3 * HT * VT + 5; i++) applyStimulus(1'b0, 1'b1);

        // Tick every other clock: strobes must stay one clock wide, levels must hold.
        for (int i = 0; i < 2 * HT * VT; i++) applyStimulus(1'b0, (i % 2) == 0);

        // Reset landing mid-frame, then the raster restarts from (0,0).
        for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 2 * HT * VT; i++) applyStimulus(1'b0, 1'b1);

        // Random tick pattern with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
        end

        // Long enough run that the frame count climbs past several frames.
        for (int i = 0; i < 4 * HT * VT; i++) applyStimulus(1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", 32'(scoreboard.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It produces horizontal/vertical sync, display-enable, pixel coordinates and line/frame event strobes for any mode described by its porch/sync parameters, with configurable sync polarity. A pixel clock-enable lets it run from a faster system clock. It sits between the clock source and the pixel-drawing logic of every VGA design in the codebase.

## Interface
- `H_VA`, 640, horizontal visible pixels
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SP`, 96, horizontal sync pulse (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VA`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SP`, 2, vertical sync pulse (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, h_sync active level (0 = active-low)
- `V_POL`, 0, v_sync active level (0 = active-low)
- `H_CW`, 10, horizontal counter/coordinate width; must hold H_TOTAL-1
- `V_CW`, 10, vertical counter/coordinate width; must hold V_TOTAL-1
- `clk`  in  1  clock, single domain
- `rst`  in  1  synchronous reset, active-high
- `pix_en`  in  1  pixel tick; all state advances only when high
- `h_sync`  out  1  registered horizontal sync, polarity per H_POL
- `v_sync`  out  1  registered vertical sync, polarity per V_POL
- `display_on`  out  1  registered; high inside visible area
- `pixel_x`  out  H_CW  registered horizontal position
- `pixel_y`  out  V_CW  registered vertical position
- `line_start`  out  1  one-clk strobe, pixel_x==0
- `frame_start`  out  1  one-clk strobe, pixel_x==0 and pixel_y==0
- `vblank_start`  out  1  one-clk strobe, pixel_x==0 and pixel_y==V_VA
- `frame_count`  out  16  frames completed since reset (see Configuration)

## Operation
- H_TOTAL = H_VA+H_FP+H_SP+H_BP; V_TOTAL likewise. Defaults give 800 × 525.
- Internal hc counts 0..H_TOTAL-1. vc counts 0..V_TOTAL-1.
- On pix_en: if hc==H_TOTAL-1, hc→0 and vc advances (vc==V_TOTAL-1 → 0); otherwise hc+1.
- Output stage registers, on pix_en, from the current (hc,vc):
  - pixel_x=hc, pixel_y=vc
  - display_on = hc<H_VA && vc<V_VA
  - h_sync = H_POL when H_VA+H_FP ≤ hc ≤ H_VA+H_FP+H_SP-1, else ~H_POL
  - v_sync = V_POL when V_VA+V_FP ≤ vc ≤ V_VA+V_FP+V_SP-1, else ~V_POL
  - Sync ranges are inclusive; width is exactly H_SP pixels / V_SP lines.
- Strobes: set on a pix_en cycle whose (hc,vc) meets the condition. Forced 0 on any cycle without pix_en. Width is always one clk.
- No other state. There is no FSM beyond the two wrapping counters.

## Timing
- Reset (rst high at clk edge) values:
  - hc=vc=0, pixel_x=pixel_y=0
  - h_sync=~H_POL, v_sync=~V_POL
  - display_on=0, all strobes=0, frame_count=0
- rst overrides pix_en. Reset mid-frame restarts the raster at (0,0) on the next pix_en.
- Latency: outputs show position p one clk after the pix_en edge that sampled counter value p. All outputs are mutually aligned.
- The first pix_en after reset gives pixel_x=0, pixel_y=0, display_on=1, frame_start=1, line_start=1.
- pix_en low: counters and all level outputs hold; strobes drop to 0.
- pix_en tied high gives one pixel per clk.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - frame_count increments (mod 2^16) on the pix_en that wraps (H_TOTAL-1,V_TOTAL-1)→(0,0).
  - The new value is visible in the same output update as frame_start.
  - The first frame after reset reads 0.
- Undefined: frame_count is constant 0, and no counter register is built.

## Test plan
- Defaults, pix_en=1, rst for 3 clk then released. Required: first output cycle (0,0) with display_on=1, frame_start=1; h_sync/v_sync high before that.
- Defaults, one line. Required: h_sync low for exactly pixel_x 656..751 (96 clk); display_on high for pixel_x 0..639; line_start period 800 clk.
- Defaults, one full frame. Required:
  - v_sync low for exactly lines 490..491.
  - vblank_start once at (0,480).
  - frame_start period 420000 clk.
  - frame_count 0→1 at the second frame_start (macro defined).
- pix_en toggling 1-0, defaults. Required: line_start period 1600 clk; each strobe one clk wide; level outputs stable while pix_en=0.
- H_POL=1, V_POL=1, H_VA=8, H_FP=2, H_SP=3, H_BP=1, V_VA=4, V_FP=1, V_SP=1, V_BP=1. Required: h_sync high for pixel_x 10..12; v_sync high on line 5; pixel_x wraps at 13→0; pixel_y wraps at 6→0.
- rst asserted at pixel (300,200) mid-frame. Required: next cycle all reset values; raster restarts at (0,0) with frame_start=1; frame_count=0.
